// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the paired-instruction fetch sequencer.
package inst_fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_PAIR_STRIDE = 32'd8;
    localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_fetch_pc_fifo.sv
// Small FIFO holding the pc of every accepted fetch request until its response
// arrives; cleared wholesale on redirect.
module fetch_pc_fifo
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    output logic [XLEN-1:0] head_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_pc;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign head_pc = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Paired-instruction fetch sequencer with credit-based buffer tracking and redirect flush.
// Optional saturating performance counters enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int          BUF_DEPTH       = 8,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_en,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [31:0]                 imem_req_addr,
    input  logic                        imem_resp_valid,
    input  logic [31:0]                 imem_resp_inst1,
    input  logic [31:0]                 imem_resp_inst2,
    output logic                        buf_wr_en,
    output logic [31:0]                 buf_wr_inst1,
    output logic [31:0]                 buf_wr_inst2,
    output logic [31:0]                 buf_wr_pc1,
    output logic [31:0]                 buf_wr_pc2,
    output logic                        buf_flush,
    input  logic [1:0]                  buf_rd_cnt,
    output logic [$clog2(BUF_DEPTH):0]  buf_count,
    output logic                        instbuf_full,
    output logic [31:0]                 perf_req_cnt,
    output logic [31:0]                 perf_drop_cnt,
    output logic [31:0]                 perf_full_cnt,
    output logic [1:0]                  dbg_state
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [1:0]       outstanding_q, outstanding_d;
    logic [1:0]       drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             resp_accept;
    logic             resp_write;
    logic             resp_drop;
    logic             credit_ok;
    logic             req_valid;
    logic             req_fire;
    logic [XLEN-1:0]  fifo_head_pc;
    int               avail;

    // Handshake: a request transfers when imem_req_valid && imem_req_ready at
    // posedge; responses have no backpressure and return in request order.

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (drop_cnt_d != '0) begin
                state_d = FETCH_DRAIN;
            end else begin
                state_d = fetch_en ? FETCH_RUN : FETCH_IDLE;
            end
        end else begin
            case (state_q)
                FETCH_IDLE:  if (fetch_en) state_d = FETCH_RUN;
                FETCH_RUN:   if (!fetch_en) state_d = FETCH_IDLE;
                FETCH_DRAIN: if (drop_cnt_q == '0) state_d = fetch_en ? FETCH_RUN : FETCH_IDLE;
                default:     state_d = FETCH_IDLE;
            endcase
        end
    end

    // Datapath and outputs
    always_comb begin
        resp_accept = imem_resp_valid && (outstanding_q != '0);
        resp_write  = rst && resp_accept && (drop_cnt_q == '0) && !redirect_valid;
        resp_drop   = resp_accept && ((drop_cnt_q != '0) || redirect_valid);

        // Conservative: a pair written this cycle is charged on top of the
        // registered count, and reads this cycle free nothing until next cycle.
        avail     = BUF_DEPTH - int'(count_q)
                    - 2 * (int'(outstanding_q) + int'(resp_write));
        credit_ok = (avail >= 2);

        req_valid = rst && (state_q == FETCH_RUN) && credit_ok
                    && (outstanding_q < 2'(MAX_OUTSTANDING)) && !redirect_valid;
        req_fire  = req_valid && imem_req_ready;

        outstanding_d = outstanding_q + 2'(req_fire) - 2'(resp_accept);

        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = outstanding_q - 2'(resp_accept);
        end else if (resp_accept && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire) begin
            pc_d = pc_q + INST_PAIR_STRIDE;
        end

        if (redirect_valid) begin
            count_d = '0;
        end else begin
            count_d = count_q + (resp_write ? CNT_W'(2) : '0) - CNT_W'(buf_rd_cnt);
        end

        imem_req_valid = req_valid;
        imem_req_addr  = pc_q;
        buf_wr_en      = resp_write;
        buf_wr_inst1   = imem_resp_inst1;
        buf_wr_inst2   = imem_resp_inst2;
        buf_wr_pc1     = fifo_head_pc;
        buf_wr_pc2     = fifo_head_pc + INST_BYTES;
        buf_flush      = rst && redirect_valid;
        buf_count      = count_q;
        instbuf_full   = !credit_ok;
        dbg_state      = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
        end
    end

    fetch_pc_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect_valid),
        .push    (req_fire),
        .push_pc (pc_q),
        .pop     (resp_write),
        .head_pc (fifo_head_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_req_q, perf_req_d;
    logic [31:0] perf_drop_q, perf_drop_d;
    logic [31:0] perf_full_q, perf_full_d;

    always_comb begin
        perf_req_d  = perf_req_q;
        perf_drop_d = perf_drop_q;
        perf_full_d = perf_full_q;
        if (req_fire && (perf_req_q != '1)) perf_req_d = perf_req_q + 32'd1;
        if (resp_drop && (perf_drop_q != '1)) perf_drop_d = perf_drop_q + 32'd1;
        if ((state_q == FETCH_RUN) && !credit_ok && (perf_full_q != '1)) begin
            perf_full_d = perf_full_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_req_q  <= '0;
            perf_drop_q <= '0;
            perf_full_q <= '0;
        end else begin
            perf_req_q  <= perf_req_d;
            perf_drop_q <= perf_drop_d;
            perf_full_q <= perf_full_d;
        end
    end

    assign perf_req_cnt  = perf_req_q;
    assign perf_drop_cnt = perf_drop_q;
    assign perf_full_cnt = perf_full_q;
`else
    assign perf_req_cnt  = '0;
    assign perf_drop_cnt = '0;
    assign perf_full_cnt = '0;
`endif

    // Illegal traffic: a response with nothing in flight, or ID reading more than is held.
    assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> (outstanding_q != '0));
    assert property (@(posedge clk) disable iff (!rst)
        CNT_W'(buf_rd_cnt) <= count_q);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: vector table for the startup fill, hand
// sequences for steady streaming, redirect, stall and mid-flight reset.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_inst1 = '0;
    logic [31:0] imem_resp_inst2 = '0;
    logic        buf_wr_en;
    logic [31:0] buf_wr_inst1, buf_wr_inst2, buf_wr_pc1, buf_wr_pc2;
    logic        buf_flush;
    logic [1:0]  buf_rd_cnt = 2'd0;
    logic [3:0]  buf_count;
    logic        instbuf_full;
    logic [31:0] perf_req_cnt, perf_drop_cnt, perf_full_cnt;
    logic [1:0]  dbg_state;

    inst_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst1 (imem_resp_inst1),
        .imem_resp_inst2 (imem_resp_inst2),
        .buf_wr_en       (buf_wr_en),
        .buf_wr_inst1    (buf_wr_inst1),
        .buf_wr_inst2    (buf_wr_inst2),
        .buf_wr_pc1      (buf_wr_pc1),
        .buf_wr_pc2      (buf_wr_pc2),
        .buf_flush       (buf_flush),
        .buf_rd_cnt      (buf_rd_cnt),
        .buf_count       (buf_count),
        .instbuf_full    (instbuf_full),
        .perf_req_cnt    (perf_req_cnt),
        .perf_drop_cnt   (perf_drop_cnt),
        .perf_full_cnt   (perf_full_cnt),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        auto_mem = 1'b0;
    logic [31:0] pend_q[$];

    typedef struct {
        logic        fetch_en;
        logic        ready;
        logic [1:0]  rd_cnt;
        logic        req_valid;
        logic [31:0] req_addr;
        logic        wr_en;
        logic [31:0] wr_pc1;
        logic [3:0]  count;
        logic        full;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Auto memory: remember accepted addresses, answer them one cycle later.
    always @(negedge clk) begin
        if (auto_mem && rst && imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
    end

    task automatic set_resp(input logic v, input logic [31:0] a);
        imem_resp_valid = v;
        imem_resp_inst1 = a ^ K;
        imem_resp_inst2 = (a + 32'd4) ^ K;
    endtask

    task automatic next_cycle();
        logic [31:0] a;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (pend_q.size() > 0) begin
                a = pend_q.pop_front();
                set_resp(1'b1, a);
            end else begin
                set_resp(1'b0, 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        buf_rd_cnt     = 2'd0;
        set_resp(1'b0, 32'd0);
        pend_q.delete();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        int          nwr;
        logic [31:0] exp_pc;

        // Startup fill: 1-cycle memory, no reads; fetch stops at 4 pairs.
        vecs[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h00, 1'b0, 32'h00, 4'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 1'b1, 32'h00, 1'b0, 32'h00, 4'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 1'b1, 32'h08, 1'b1, 32'h00, 4'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 1'b1, 32'h10, 1'b1, 32'h08, 4'd2, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h18, 1'b1, 32'h10, 4'd4, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 1'b1, 32'h18, 1'b0, 32'h00, 4'd6, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 1'b1, 32'h18, 4'd6, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 1'b0, 32'h00, 4'd8, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 1'b0, 32'h00, 4'd8, 1'b1};

        auto_mem = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_wr_en", buf_wr_en, 0);
        check("rst_flush", buf_flush, 0);
        check("rst_count", buf_count, 0);
        check("rst_full", instbuf_full, 0);
        check("rst_state", dbg_state, FETCH_IDLE);
        check("rst_perf", perf_req_cnt | perf_drop_cnt | perf_full_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            next_cycle();
            rst            = 1'b1;
            fetch_en       = vecs[i].fetch_en;
            imem_req_ready = vecs[i].ready;
            buf_rd_cnt     = vecs[i].rd_cnt;
            @(negedge clk);
            check($sformatf("fill%0d_req_valid", i), imem_req_valid, vecs[i].req_valid);
            check($sformatf("fill%0d_req_addr", i), imem_req_addr, vecs[i].req_addr);
            check($sformatf("fill%0d_wr_en", i), buf_wr_en, vecs[i].wr_en);
            check($sformatf("fill%0d_count", i), buf_count, vecs[i].count);
            check($sformatf("fill%0d_full", i), instbuf_full, vecs[i].full);
            if (vecs[i].wr_en) begin
                check($sformatf("fill%0d_pc1", i), buf_wr_pc1, vecs[i].wr_pc1);
                check($sformatf("fill%0d_inst2", i), buf_wr_inst2, (vecs[i].wr_pc1 + 32'd4) ^ K);
            end
        end

        // Steady streaming: ID drains two per cycle.
        nwr    = 0;
        exp_pc = 32'h20;
        for (int i = 1; i <= 14; i++) begin
            next_cycle();
            buf_rd_cnt = 2'd2;
            @(negedge clk);
            check($sformatf("stream%0d_count_le8", i), {31'b0, buf_count <= 4'd8}, 1);
            if (i >= 5) check($sformatf("stream%0d_req_valid", i), imem_req_valid, 1);
            if (buf_wr_en) begin
                check($sformatf("stream%0d_pc1", i), buf_wr_pc1, exp_pc);
                check($sformatf("stream%0d_pc2", i), buf_wr_pc2, exp_pc + 32'd4);
                check($sformatf("stream%0d_inst1", i), buf_wr_inst1, exp_pc ^ K);
                exp_pc = exp_pc + 32'd8;
                nwr++;
            end
        end
        check("stream_writes", nwr, 11);

        // Redirect with two requests in flight.
        auto_mem = 1'b0;
        do_reset();
        next_cycle(); rst = 1'b1;
        next_cycle(); @(negedge clk);
        check("rd_req0_addr", imem_req_addr, 32'h0);
        next_cycle(); @(negedge clk);
        check("rd_req1_addr", imem_req_addr, 32'h8);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        check("rd_flush", buf_flush, 1);
        check("rd_req_valid", imem_req_valid, 0);
        next_cycle();
        redirect_valid = 1'b0;
        set_resp(1'b1, 32'h0);
        @(negedge clk);
        check("drain_state", dbg_state, FETCH_DRAIN);
        check("drain_wr0", buf_wr_en, 0);
        check("drain_count", buf_count, 0);
        check("drain_req_valid", imem_req_valid, 0);
        next_cycle();
        set_resp(1'b1, 32'h8);
        @(negedge clk);
        check("drain_wr1", buf_wr_en, 0);
        next_cycle();
        set_resp(1'b0, 32'h0);
        @(negedge clk);
        check("drain_last_state", dbg_state, FETCH_DRAIN);
        check("drain_last_req", imem_req_valid, 0);
        next_cycle(); @(negedge clk);
        check("post_drain_state", dbg_state, FETCH_RUN);
        check("post_drain_req_valid", imem_req_valid, 1);
        check("post_drain_addr", imem_req_addr, 32'h100);
        next_cycle();
        set_resp(1'b1, 32'h100);
        @(negedge clk);
        check("post_drain_wr", buf_wr_en, 1);
        check("post_drain_pc1", buf_wr_pc1, 32'h100);
        check("post_drain_pc2", buf_wr_pc2, 32'h104);
        check("post_drain_inst1", buf_wr_inst1, 32'h100 ^ K);
        check("post_drain_next_addr", imem_req_addr, 32'h108);

        // Redirect coincident with a response and an otherwise offered request.
        next_cycle();
        set_resp(1'b1, 32'h108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("coinc_wr", buf_wr_en, 0);
        check("coinc_req_valid", imem_req_valid, 0);
        check("coinc_flush", buf_flush, 1);
        next_cycle();
        redirect_valid = 1'b0;
        set_resp(1'b0, 32'h0);
        @(negedge clk);
        check("coinc_state", dbg_state, FETCH_RUN);
        check("coinc_count", buf_count, 0);
        check("coinc_req_valid_next", imem_req_valid, 1);
        check("coinc_addr_next", imem_req_addr, 32'h200);

        // Memory stall: ready low for five cycles.
        next_cycle();
        set_resp(1'b1, 32'h200);
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("stall_wr_pc1", buf_wr_pc1, 32'h200);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                next_cycle();
                set_resp(1'b0, 32'h0);
                @(negedge clk);
                check($sformatf("stall%0d_count", i), buf_count, 2);
            end
            check($sformatf("stall%0d_valid", i), imem_req_valid, 1);
            check($sformatf("stall%0d_addr", i), imem_req_addr, 32'h208);
        end
        next_cycle();
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("stall_accept_addr", imem_req_addr, 32'h208);
        next_cycle(); @(negedge clk);
        check("stall_next_addr", imem_req_addr, 32'h210);
        check("stall_next_valid", imem_req_valid, 1);

        // Reset with two in flight; a late response arrives during reset.
        next_cycle();
        rst = 1'b0;
        set_resp(1'b1, 32'h208);
        @(negedge clk);
        check("mrst_wr", buf_wr_en, 0);
        check("mrst_req", imem_req_valid, 0);
        next_cycle();
        rst = 1'b1;
        set_resp(1'b0, 32'h0);
        @(negedge clk);
        check("mrst_state", dbg_state, FETCH_IDLE);
        check("mrst_count", buf_count, 0);
        check("mrst_wr_after", buf_wr_en, 0);
        next_cycle(); @(negedge clk);
        check("mrst_restart_valid", imem_req_valid, 1);
        check("mrst_restart_addr", imem_req_addr, 32'h0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
